// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_ctrl_pkg
// Description : Shared types, constants and {real,imag} packing helpers for
//               the FFT frame controller and its skid FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Depth of the skid FIFO between the sample RAM and the core sink.
    localparam int C_FIFO_DEPTH = 2;

    // Packs two components of width dw (<= 32) into {re,im} in the low 2*dw
    // bits of a 64-bit word; callers truncate to their own word width.
    function automatic logic [63:0] pack_iq(input logic [31:0] re,
                                            input logic [31:0] im,
                                            input int          dw);
        logic [63:0] mask;
        mask = (64'd1 << dw) - 64'd1;
        return (({32'd0, re} & mask) << dw) | ({32'd0, im} & mask);
    endfunction

    function automatic logic [31:0] iq_real(input logic [63:0] w, input int dw);
        return 32'((w >> dw) & ((64'd1 << dw) - 64'd1));
    endfunction

    function automatic logic [31:0] iq_imag(input logic [63:0] w, input int dw);
        return 32'(w & ((64'd1 << dw) - 64'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fft_skid_fifo
// Description : Two-entry skid FIFO. Push and pop may occur in the same cycle
//               when the FIFO is non-empty; push into a full FIFO is only
//               accepted when a pop frees a slot in the same cycle.
// Ports       : clk, reset (sync, active-high); push/push_data in;
//               pop in, pop_data out (head word); full, empty, count out.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_skid_fifo
    import fft_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [C_FIFO_DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == 2'(C_FIFO_DEPTH));
    assign empty    = (r_count == 2'd0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rptr];

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Storage needs no reset: the head word is only observed when non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Sequences one FFT frame: streams FFT_LEN samples from the
//               sample RAM into the core sink (sop/eop, backpressure) through
//               a 2-entry skid FIFO, and writes the core source stream into the
//               result RAM, capturing the block exponent and protocol errors.
// Ports       : clk, reset (sync, active-high); start/inverse_cfg control in;
//               busy/done/err/exp_out status out; rd_* sample RAM port;
//               wr_* result RAM port; fft_sink_* to core; fft_source_* from
//               core; fft_inverse latched direction to core.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_LEN = 1024,
    parameter int AW      = 10,
    parameter int DW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            inverse_cfg,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [5:0]      exp_out,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [2*DW-1:0] rd_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [2*DW-1:0] wr_data,
    output logic            fft_sink_valid,
    output logic            fft_sink_sop,
    output logic            fft_sink_eop,
    output logic [1:0]      fft_sink_error,
    output logic [DW-1:0]   fft_sink_real,
    output logic [DW-1:0]   fft_sink_imag,
    input  logic            fft_sink_ready,
    output logic            fft_inverse,
    input  logic            fft_source_valid,
    input  logic            fft_source_sop,
    input  logic            fft_source_eop,
    input  logic [1:0]      fft_source_error,
    input  logic [DW-1:0]   fft_source_real,
    input  logic [DW-1:0]   fft_source_imag,
    input  logic [5:0]      fft_source_exp,
    output logic            fft_source_ready
);

    localparam logic [AW:0] C_LEN  = (AW+1)'(FFT_LEN);
    localparam logic [AW:0] C_LAST = (AW+1)'(FFT_LEN - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [AW:0]     r_rd_cnt;
    logic [AW:0]     r_in_cnt;
    logic [AW:0]     r_wr_cnt;
    logic            r_rd_pending;
    logic            r_err;
    logic            r_inverse;
    logic [5:0]      r_exp;

    logic            w_run;
    logic            w_start_ok;
    logic            w_rd_en;
    logic            w_sink_beat;
    logic            w_src_beat;
    logic            w_wr_en;
    logic            w_src_bad;
    logic [2:0]      w_level;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [1:0]      w_fifo_count;
    logic [2*DW-1:0] w_fifo_dout;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (r_in_cnt == C_LEN && r_wr_cnt == C_LEN) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_start_ok = (r_state == IDLE) && start;

    // ---------------- Feed ----------------
    assign fft_sink_valid = w_run && !w_fifo_empty;
    assign w_sink_beat    = fft_sink_valid && fft_sink_ready;

    // Occupancy after this cycle's pop plus the read already in flight.
    // Counting the pop lets a new read issue every cycle while ready is high.
    assign w_level = 3'(w_fifo_count) + 3'(r_rd_pending) - 3'(w_sink_beat);
    assign w_rd_en = w_run && (r_rd_cnt < C_LEN) && (w_level < 3'(C_FIFO_DEPTH))
                     && !(w_fifo_full && !w_sink_beat);

    assign rd_en   = w_rd_en;
    assign rd_addr = w_rd_en ? r_rd_cnt[AW-1:0] : '0;

    fft_skid_fifo #(.WIDTH(2*DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (r_rd_pending),
        .push_data (rd_data),
        .pop       (w_sink_beat),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign fft_sink_sop   = fft_sink_valid && (r_in_cnt == '0);
    assign fft_sink_eop   = fft_sink_valid && (r_in_cnt == C_LAST);
    assign fft_sink_error = 2'b00;
    assign fft_sink_real  = fft_sink_valid ? DW'(iq_real(64'(w_fifo_dout), DW)) : '0;
    assign fft_sink_imag  = fft_sink_valid ? DW'(iq_imag(64'(w_fifo_dout), DW)) : '0;
    assign fft_inverse    = r_inverse;

    // ---------------- Collect ----------------
    assign fft_source_ready = w_run;
    assign w_src_beat       = w_run && fft_source_valid;
    assign w_wr_en          = w_src_beat && (r_wr_cnt < C_LEN);
    assign wr_en            = w_wr_en;
    assign wr_addr          = w_wr_en ? r_wr_cnt[AW-1:0] : '0;
    assign wr_data          = w_wr_en ? (2*DW)'(pack_iq(32'(fft_source_real),
                                                        32'(fft_source_imag), DW)) : '0;

    assign w_src_bad = (fft_source_error != 2'b00)
                    || (fft_source_sop != (r_wr_cnt == '0))
                    || (fft_source_eop != (r_wr_cnt == C_LAST));

    assign err     = r_err;
    assign exp_out = r_exp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt     <= '0;
            r_in_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_rd_pending <= 1'b0;
            r_err        <= 1'b0;
            r_inverse    <= 1'b0;
            r_exp        <= 6'd0;
        end else begin
            r_rd_pending <= w_rd_en;
            if (w_start_ok) begin
                r_rd_cnt  <= '0;
                r_in_cnt  <= '0;
                r_wr_cnt  <= '0;
                r_err     <= 1'b0;
                r_inverse <= inverse_cfg;
            end else if (w_run) begin
                if (w_rd_en)     r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_sink_beat) r_in_cnt <= r_in_cnt + 1'b1;
                if (w_src_beat) begin
                    if (w_wr_en) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (fft_source_sop) r_exp <= fft_source_exp;
                        if (w_src_bad)      r_err <= 1'b1;
                    end else begin
                        // Surplus beat beyond the frame: dropped and flagged.
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
